// File: rtl/fetch_align_pkg.sv
// Shared constants, state encoding and J-immediate decode for the fetch aligner.
package fetch_align_pkg;

    localparam int unsigned TABLESIZE  = 10;
    localparam int unsigned ISSUEWIDTH = 4;

    localparam logic [6:0]  JAL_OPCODE = 7'b1101111;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [7:0]  FLUSH_CUT  = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StLine,
        StOut,
        StFlush,
        StDrain
    } state_e;

    // Sign-extended J-type immediate (byte offset).
    function automatic logic [31:0] jal_imm(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_align_if.sv
// Redirect, I-memory and output-beat signals of the fetch aligner.
interface fetch_align_if #(
    parameter int unsigned TABLESIZE = fetch_align_pkg::TABLESIZE
);
    logic                      i_redirect;
    logic [31:0]               i_redirectPC;
    logic                      o_memReq;
    logic [31:0]               o_memAddr;
    logic                      i_memValid;
    logic [32*TABLESIZE-1:0]   i_memData;
    logic [7:0]                i_room;
    logic                      o_valid;
    logic                      i_ready;
    logic [64*TABLESIZE-1:0]   o_alignedInstructionTable;
    logic [7:0]                o_cutPostion_8;

    // Aligner side.
    modport master (
        input  i_redirect, i_redirectPC, i_memValid, i_memData, i_room, i_ready,
        output o_memReq, o_memAddr, o_valid, o_alignedInstructionTable, o_cutPostion_8
    );

    // Memory / queue / redirect source side.
    modport slave (
        output i_redirect, i_redirectPC, i_memValid, i_memData, i_room, i_ready,
        input  o_memReq, o_memAddr, o_valid, o_alignedInstructionTable, o_cutPostion_8
    );
endinterface

// File: rtl/fetch_align_jal_cut_finder.sv
// Finds the first JAL among the n valid words of a line and its jump target.
module jal_cut_finder
    import fetch_align_pkg::*;
#(
    parameter int unsigned TABLESIZE = fetch_align_pkg::TABLESIZE
) (
    input  logic [32*TABLESIZE-1:0] line_i,
    input  logic [31:0]             base_pc_i,
    input  logic [7:0]              n_i,
    output logic [7:0]              cut_o,
    output logic                    is_jal_o,
    output logic [31:0]             target_o
);

    // Scan high to low so the lowest-index JAL is the one that sticks.
    always_comb begin
        cut_o    = n_i - 8'd1;
        is_jal_o = 1'b0;
        target_o = '0;
        for (int k = TABLESIZE - 1; k >= 0; k--) begin
            if (8'(k) < n_i && line_i[32*k +: 7] == JAL_OPCODE) begin
                cut_o    = 8'(k);
                is_jal_o = 1'b1;
                target_o = base_pc_i + 32'(4 * k) + jal_imm(line_i[32*k +: 32]);
            end
        end
    end

endmodule

// File: rtl/fetch_align.sv
// Fetches instruction lines, cuts them at the first JAL or at queue room, and emits
// PC-tagged instruction tables; redirects produce a flush beat.
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter int unsigned TABLESIZE = fetch_align_pkg::TABLESIZE,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    fetch_align_if.master bus
);

    state_e                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic [31:0]             next_pc_q, next_pc_d;
    logic                    discard_q, discard_d;
    logic [32*TABLESIZE-1:0] line_q, line_d;
    logic [64*TABLESIZE-1:0] table_q, table_d;
    logic [7:0]              cut_q, cut_d;

    logic [7:0]              n_c;
    logic [7:0]              cut_c;
    logic                    is_jal_c;
    logic [31:0]             target_c;
    logic [64*TABLESIZE-1:0] tbl_c;

    // Valid count is clamped to the table size.
    assign n_c = (bus.i_room > 8'(TABLESIZE)) ? 8'(TABLESIZE) : bus.i_room;

    jal_cut_finder #(
        .TABLESIZE (TABLESIZE)
    ) u_cut_finder (
        .line_i    (line_q),
        .base_pc_i (pc_q),
        .n_i       (n_c),
        .cut_o     (cut_c),
        .is_jal_o  (is_jal_c),
        .target_o  (target_c)
    );

    // Build the PC-tagged table; entries past the cut stay zero.
    always_comb begin
        tbl_c = '0;
        for (int k = 0; k < TABLESIZE; k++) begin
            if (8'(k) <= cut_c) begin
                tbl_c[64*k +: 64] = {pc_q + 32'(4 * k), line_q[32*k +: 32]};
            end
        end
    end

    // Next-state logic; a redirect overrides every other transition.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        discard_d = discard_q;
        line_d    = line_q;
        table_d   = table_q;
        cut_d     = cut_q;
        if (bus.i_redirect) begin
            state_d = StFlush;
            pc_d    = bus.i_redirectPC;
            table_d = '0;
            cut_d   = FLUSH_CUT;
            // A request issued from REQ is always still in flight; in WAIT/DRAIN a
            // same-cycle response is simply swallowed.
            if (state_q == StReq) begin
                discard_d = 1'b1;
            end else if (state_q == StWait || state_q == StDrain) begin
                discard_d = !bus.i_memValid;
            end
        end else begin
            case (state_q)
                StIdle: state_d = StReq;
                StReq:  state_d = StWait;
                StWait: begin
                    if (bus.i_memValid) begin
                        line_d  = bus.i_memData;
                        state_d = StLine;
                    end
                end
                StLine: begin
                    if (bus.i_room != 8'd0) begin
                        table_d   = tbl_c;
                        cut_d     = cut_c;
                        next_pc_d = is_jal_c ? target_c : pc_q + 32'({n_c, 2'b00});
                        state_d   = StOut;
                    end
                end
                StOut: begin
                    if (bus.i_ready) begin
                        pc_d    = next_pc_q;
                        state_d = StReq;
                    end
                end
                StFlush: begin
                    if (bus.i_ready) begin
                        state_d = discard_q ? StDrain : StReq;
                    end
                end
                StDrain: begin
                    if (bus.i_memValid) begin
                        discard_d = 1'b0;
                        state_d   = StReq;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            next_pc_q <= RESET_PC;
            discard_q <= 1'b0;
            line_q    <= '0;
            table_q   <= '0;
            cut_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            discard_q <= discard_d;
            line_q    <= line_d;
            table_q   <= table_d;
            cut_q     <= cut_d;
        end
    end

    assign bus.o_memReq                  = (state_q == StReq);
    assign bus.o_memAddr                 = pc_q;
    assign bus.o_valid                   = (state_q == StOut) || (state_q == StFlush);
    assign bus.o_alignedInstructionTable = table_q;
    assign bus.o_cutPostion_8            = cut_q;

endmodule

// File: tb/tb_fetch_align.sv
// Directed bench for fetch_align: reset, plain lines, room limits, JAL cut, stall, redirect.
module tb_fetch_align;

    localparam int TS = 10;
    localparam int LW = 64 * TS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    fetch_align_if #(.TABLESIZE(TS)) bus ();

    fetch_align #(
        .TABLESIZE (TS),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Word k of a line fetched at base: non-JAL (opcode 0x13) tagged with its address.
    function automatic logic [32*TS-1:0] mk_line(input logic [31:0] base);
        logic [32*TS-1:0] l;
        for (int k = 0; k < TS; k++) l[32*k +: 32] = ((base + 32'(4 * k)) << 8) | 32'h13;
        return l;
    endfunction

    function automatic logic [LW-1:0] exp_tbl(input logic [31:0] base,
                                              input logic [32*TS-1:0] l, input int cut);
        logic [LW-1:0] t;
        t = '0;
        for (int k = 0; k <= cut; k++) t[64*k +: 64] = {base + 32'(4 * k), l[32*k +: 32]};
        return t;
    endfunction

    function automatic logic [63:0] entry(input int k);
        return bus.o_alignedInstructionTable[64*k +: 64];
    endfunction

    // Called at a negedge; waits for the request, answers in the first WAIT cycle,
    // returns at the negedge of the LINE cycle.
    task automatic serve(input string tag, input logic [31:0] addr, input logic [32*TS-1:0] data);
        int n = 0;
        while (!bus.o_memReq && n < 50) begin @(negedge clk); n++; end
        check({tag, "_req"}, LW'(bus.o_memReq), LW'(1));
        check({tag, "_addr"}, LW'(bus.o_memAddr), LW'(addr));
        @(negedge clk);
        bus.i_memValid = 1'b1;
        bus.i_memData  = data;
        @(negedge clk);
        bus.i_memValid = 1'b0;
    endtask

    task automatic wait_beat(input string tag);
        int n = 0;
        while (!bus.o_valid && n < 20) begin @(negedge clk); n++; end
        check({tag, "_valid"}, LW'(bus.o_valid), LW'(1));
    endtask

    task automatic accept();
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
    endtask

    initial begin
        logic [32*TS-1:0] l;
        int               cnt;

        bus.i_redirect   = 1'b0;
        bus.i_redirectPC = '0;
        bus.i_memValid   = 1'b0;
        bus.i_memData    = '0;
        bus.i_room       = 8'd20;
        bus.i_ready      = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_memreq", LW'(bus.o_memReq), LW'(0));
        check("rst_valid", LW'(bus.o_valid), LW'(0));
        check("rst_cut", LW'(bus.o_cutPostion_8), LW'(0));
        check("rst_table", bus.o_alignedInstructionTable, '0);
        rst = 1'b0;

        // Full line, no JAL, room 20; minimum latency.
        l = mk_line(32'h0);
        serve("t1", 32'h0, l);
        check("t1_lat_line", LW'(bus.o_valid), LW'(0));
        @(negedge clk);
        check("t1_lat_out", LW'(bus.o_valid), LW'(1));
        check("t1_cut", LW'(bus.o_cutPostion_8), LW'(9));
        check("t1_e0", LW'(entry(0)), LW'(64'h0000_0000_0000_0013));
        check("t1_e9", LW'(entry(9)), LW'(64'h0000_0024_0000_2413));
        check("t1_table", bus.o_alignedInstructionTable, exp_tbl(32'h0, l, 9));
        accept();

        // Room 3.
        bus.i_room = 8'd3;
        l = mk_line(32'd40);
        serve("t2", 32'd40, l);
        wait_beat("t2");
        check("t2_cut", LW'(bus.o_cutPostion_8), LW'(2));
        check("t2_e3", LW'(entry(3)), '0);
        check("t2_table", bus.o_alignedInstructionTable, exp_tbl(32'd40, l, 2));
        accept();

        // No room for 5 cycles, then room 4.
        bus.i_room = 8'd0;
        l = mk_line(32'd52);
        serve("t3", 32'd52, l);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.o_valid) cnt++;
            @(negedge clk);
        end
        check("t3_no_beat", LW'(cnt), LW'(0));
        bus.i_room = 8'd4;
        wait_beat("t3");
        check("t3_cut", LW'(bus.o_cutPostion_8), LW'(3));
        check("t3_table", bus.o_alignedInstructionTable, exp_tbl(32'd52, l, 3));
        accept();

        // JAL +0x100 at word 4, room 10; hold ready low 4 cycles.
        bus.i_room = 8'd10;
        l = mk_line(32'd68);
        l[32*4 +: 32] = 32'h1000_00EF;
        serve("t4", 32'd68, l);
        wait_beat("t4");
        check("t4_e4", LW'(entry(4)), LW'(64'h0000_0054_1000_00EF));
        for (int i = 0; i < 4; i++) begin
            check("t4_hold_valid", LW'(bus.o_valid), LW'(1));
            check("t4_hold_cut", LW'(bus.o_cutPostion_8), LW'(4));
            check("t4_hold_table", bus.o_alignedInstructionTable, exp_tbl(32'd68, l, 4));
            @(negedge clk);
        end
        accept();
        check("t4_one_beat", LW'(bus.o_valid), LW'(0));
        check("t4_next_addr", LW'(bus.o_memAddr), LW'(32'h154));

        // Redirect to 0x800 while waiting; stale response arrives in DRAIN.
        check("t5_req", LW'(bus.o_memReq), LW'(1));
        @(negedge clk);
        bus.i_redirect   = 1'b1;
        bus.i_redirectPC = 32'h800;
        @(negedge clk);
        bus.i_redirect = 1'b0;
        check("t5_flush_valid", LW'(bus.o_valid), LW'(1));
        check("t5_flush_cut", LW'(bus.o_cutPostion_8), LW'(8'hFF));
        check("t5_flush_table", bus.o_alignedInstructionTable, '0);
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready    = 1'b0;
        bus.i_memValid = 1'b1;
        bus.i_memData  = mk_line(32'h154);
        check("t5_drain_noreq", LW'(bus.o_memReq), LW'(0));
        @(negedge clk);
        bus.i_memValid = 1'b0;
        l = mk_line(32'h800);
        serve("t5", 32'h800, l);
        wait_beat("t5");
        check("t5_cut", LW'(bus.o_cutPostion_8), LW'(9));
        check("t5_table", bus.o_alignedInstructionTable, exp_tbl(32'h800, l, 9));
        accept();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_align.md
FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 Parameter TABLESIZE, default 10: entries per fetch line and per output table.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: fetch PC after reset.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 i_redirect / i_redirectPC  in  1 / 32  redirect pulse and target PC, word aligned.
REQ-006 o_memReq / o_memAddr  out  1 / 32  one-cycle I-memory line request and its PC.
REQ-007 i_memValid / i_memData  in  1 / 32*TABLESIZE  response; word k is the instruction at memAddr+4k.
REQ-008 i_room  in  8  free entries reported by the downstream instruction queue.
REQ-009 o_valid / i_ready  out / in  1 / 1  output beat handshake.
REQ-010 o_alignedInstructionTable  out  64*TABLESIZE  entry k at [64k+63:64k] = {PC[31:0], instr[31:0]}.
REQ-011 o_cutPostion_8  out  8  index of last valid entry; 8'hFF means flush downstream queue.

Function
REQ-012 FSM states SHALL be IDLE, REQ, WAIT, LINE, OUT, FLUSH, DRAIN.
REQ-013 IDLE -> REQ unconditionally; REQ asserts o_memReq=1, o_memAddr=pc for exactly one cycle, -> WAIT.
REQ-014 WAIT: on i_memValid capture i_memData into a line register, -> LINE; otherwise hold.
REQ-015 LINE: if i_room==0 hold; else register table and cut, -> OUT.
REQ-016 Valid count n = min(i_room, TABLESIZE), 8-bit compare.
REQ-017 Entry k (k<n) PC = pc + 4k (32-bit wrap), instr = line word k.
REQ-018 Cut = index of first entry k<n whose opcode[6:0] == 7'b1101111 (JAL); if none, cut = n-1.
REQ-019 Entries with index > cut SHALL be all-zero.
REQ-020 Next PC = PC_cut + sign-extended J-immediate if cut entry is JAL, else pc + 4*n.
REQ-021 OUT: o_valid=1, table and cut stable until i_ready; on i_ready pc <= next PC, -> REQ.
REQ-022 Redirect from any state SHALL set pc <= i_redirectPC, -> FLUSH; it has priority over every other transition.
REQ-023 Redirect in WAIT without i_memValid in the same cycle SHALL set a discard flag. Redirect in WAIT with i_memValid in the same cycle SHALL drop that response and leave the flag clear.
REQ-024 Redirect in OUT coinciding with i_ready: the beat counts as transferred, and the flush beat follows.
REQ-025 FLUSH: o_valid=1, cut=8'hFF, table all-zero. On i_ready, -> DRAIN if discard is set, else -> REQ. A further redirect updates pc and stays in FLUSH.
REQ-026 DRAIN: wait for i_memValid, drop the data, clear discard, -> REQ.
REQ-027 At most one memory request SHALL be outstanding.
REQ-028 Minimum latency request -> beat is 3 cycles (REQ, WAIT with immediate response, LINE), with o_valid high in the 4th cycle.

Reset
REQ-029 rst SHALL asynchronously force state=IDLE, pc=RESET_PC, discard=0, o_memReq=0, o_valid=0, table=0, cut=0.
REQ-030 A response arriving after rst deasserts, for a request issued before reset, is outside the memory contract; the memory is reset with the same rst.

Structure
REQ-031 Shared package holds TABLESIZE, ISSUEWIDTH=4, the JAL opcode, the NOP word 32'h13, the flush code 8'hFF, and the state encoding.
REQ-032 One sub-module, jal_cut_finder, is combinational: line, base PC and n in; cut, isJal and target out.

Verification
REQ-033 Reset, no JAL, i_room=20, immediate response -> first beat cut=9, entry0={0,w0}, entry9 PC=36; next o_memAddr=40.
REQ-034 i_room=3, no JAL -> cut=2, entries 3..9 zero, next PC = pc+12.
REQ-035 JAL (imm=+0x100) at word 4, room=10 -> cut=4, entries 5..9 zero, next o_memAddr = PC_4+0x100.
REQ-036 i_room=0 for 5 cycles in LINE -> no o_valid; room=4 -> beat with cut=3.
REQ-037 Redirect to 0x800 in WAIT, response 2 cycles later -> flush beat (cut=FF, table 0); stale line dropped; next o_memAddr=0x800.
REQ-038 i_ready low 4 cycles during OUT -> outputs bit-stable throughout; exactly one beat is transferred.
